// File: rtl/fsm_latch_arbiter_pkg.sv
// Shared constants for the latch arbiter: latch FSM command codes and controller state encoding.
package fsm_latch_arbiter_pkg;

  localparam logic [2:0] CODE_IDLE = 3'b000;
  localparam logic [2:0] CODE_SET  = 3'b011;
  localparam logic [2:0] CODE_CLR  = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [2:0] op_code(input logic op);
    return op ? CODE_SET : CODE_CLR;
  endfunction

endpackage

// File: rtl/fsm_latch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module fsm_latch_arbiter_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pick,
  output logic                     valid
);

  localparam int PTR_W = $clog2(N_REQ);

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && req[rot_idx(ptr, i)]) begin
        pick[rot_idx(ptr, i)] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_latch_arbiter.sv
// Round-robin arbiter sharing one set/clear latch FSM; drives codes, verifies latch_out, then grants.
// Optional macro FSM_LATCH_SKIP_REDUNDANT_EN: skip ISSUE/CHECK when the latch already holds the requested value.
module fsm_latch_arbiter
  import fsm_latch_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int TIMEOUT     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_set,
  output logic [2:0]       code_out,
  input  logic             latch_out,
  output logic [N_REQ-1:0] gnt,
  output logic             err,
  output logic             busy
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic             op_q, op_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       code_q, code_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick;
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;

  fsm_latch_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    code_d  = CODE_IDLE;
    gnt_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d = pick_idx;
          op_d  = req_set[pick_idx];
`ifdef FSM_LATCH_SKIP_REDUNDANT_EN
          if (latch_out == req_set[pick_idx]) begin
            state_d = ST_DONE;
            gnt_d   = pick;
          end else begin
            state_d = ST_ISSUE;
            code_d  = op_code(req_set[pick_idx]);
            hold_d  = HOLD_W'(1);
          end
`else
          state_d = ST_ISSUE;
          code_d  = op_code(req_set[pick_idx]);
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      ST_ISSUE: begin
        // hold_q counts code cycles already on the bus, including the one now showing
        if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
          state_d = ST_CHECK;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          code_d = op_code(op_q);
        end
      end
      ST_CHECK: begin
        if (latch_out == op_q) begin
          state_d      = ST_DONE;
          gnt_d[win_q] = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d      = ST_DONE;
          gnt_d[win_q] = 1'b1;
          err_d        = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      code_q  <= CODE_IDLE;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
    win_q <= win_d;
    op_q  <= op_d;
  end

  assign code_out = code_q;
  assign gnt      = gnt_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/fsm_latch_arbiter.md
Name: fsm_latch_arbiter

Overview:
- Shares one set/clear latch FSM among N_REQ requesters.
- The latch FSM takes a 3-bit code: 3'b011 sets its output, 3'b100 clears it, any other code holds it.
- This block arbitrates round-robin, drives the code bus, checks that the latch output reached the requested value, then acknowledges the winner.
- It sits between the requester logic and the latch FSM, on the same clock.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- HOLD_CYCLES, 1, cycles the set/clear code is driven per operation (≥1).
- TIMEOUT, 8, maximum CHECK cycles waiting for latch_out to match (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until its gnt.
- req_set  in  N_REQ  per-requester op: 1=set, 0=clear; sampled with req at arbitration.
- code_out  out  3  registered code to the latch FSM input.
- latch_out  in  1  latch FSM output.
- gnt  out  N_REQ  registered one-hot, 1-cycle acknowledge pulse.
- err  out  1  registered 1-cycle pulse, coincident with gnt, on timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - state=IDLE, code_out=3'b000, gnt=0, err=0, busy=0.
  - RR pointer=0, counters=0.
- Reset mid-operation aborts the operation. No gnt is issued for it. code_out returns to 3'b000 at that edge.
- States: IDLE, ISSUE, CHECK, DONE.
- IDLE:
  - If req≠0, the round-robin pick registers winner index W and op=req_set[W], then moves to ISSUE.
  - Priority search starts at pointer, ascending, wrapping at N_REQ-1→0.
- ISSUE:
  - code_out = op ? 3'b011 : 3'b100 for exactly HOLD_CYCLES cycles.
  - Then code_out=3'b000 and state moves to CHECK.
- CHECK:
  - Each cycle, compare latch_out to op.
  - On match → DONE, err_next=0.
  - After TIMEOUT cycles with no match → DONE, err_next=1.
- DONE (one cycle):
  - gnt[W]=1; err=err_next.
  - Pointer becomes (W+1) mod N_REQ.
  - Next state is IDLE.
- Latency, HOLD_CYCLES=1, normal latch: req seen in IDLE at cycle 0 → code_out valid cycle 1 → latch_out updated cycle 2 (match in CHECK) → gnt at cycle 3.
- A new arbitration is possible in the cycle after DONE. gnt and err are never asserted in the same cycle as code_out≠0.
- Requester dropping req mid-operation: the operation completes and gnt still pulses. The requester ignores it.
- Requests arriving during a busy period wait. Only IDLE arbitrates.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(TIMEOUT+1).
- code_out is never 3'b011 or 3'b100 outside ISSUE.

Optional Feature:
- Macro: FSM_LATCH_SKIP_REDUNDANT_EN.
- Defined: in IDLE, if latch_out already equals req_set[W], the state goes IDLE→DONE directly. No code is issued, err=0, and gnt arrives one cycle after arbitration.
- Undefined: every granted operation passes through ISSUE and CHECK regardless of latch_out.

Decomposition:
- Shared package (fsm_defs include/package) holds:
  - CODE_SET=3'b011, CODE_CLR=3'b100, CODE_IDLE=3'b000.
  - State encoding IDLE=2'd0, ISSUE=2'd1, CHECK=2'd2, DONE=2'd3.
- Sub-module rr_arbiter (N_REQ parameter): inputs req and pointer, outputs one-hot pick plus valid. It is combinational. The pointer register stays in fsm_latch_arbiter.

Test Plan:
1. Single request, set: req=4'b0001, req_set=4'b0001, latch model real → code_out=011 at cycle 1, latch_out=1 at cycle 2, gnt=4'b0001 at cycle 3, err=0.
2. Round-robin: req=4'b1111 held, alternating req_set → grants in order 0001,0010,0100,1000,0001. Each gnt is 4 cycles after the previous DONE+1 (HOLD_CYCLES=1).
3. Timeout: latch_out tied 0, req=4'b0100 set → code_out=011 for one cycle, CHECK 8 cycles, then gnt=4'b0100 with err=1 at cycle 10.
4. Reset mid-op: assert reset during ISSUE → next cycle code_out=000, busy=0, no gnt. After reset, a req=4'b0010 is granted before 4'b0001 only if the pointer has passed it; verify pointer=0 (4'b0001 wins when both request).
5. HOLD_CYCLES=3: clear request → code_out=100 for exactly 3 cycles, then 000, then gnt.
6. FSM_LATCH_SKIP_REDUNDANT_EN defined, latch_out=1, set request on req[2] → gnt=4'b0100 one cycle after arbitration, code_out stays 000. Without the macro, the full 3-cycle path is taken.
